// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and report payload for the signed 7-segment decoder.
package seg7_pkg;

  // Active-low digit codes, DP (bit 7) high
  localparam logic [7:0] DIG_0 = 8'hC0;
  localparam logic [7:0] DIG_1 = 8'hF9;
  localparam logic [7:0] DIG_2 = 8'hA4;
  localparam logic [7:0] DIG_3 = 8'hB0;
  localparam logic [7:0] DIG_4 = 8'h99;
  localparam logic [7:0] DIG_5 = 8'h92;
  localparam logic [7:0] DIG_6 = 8'h82;
  localparam logic [7:0] DIG_7 = 8'hF8;
  localparam logic [7:0] DIG_8 = 8'h80;

  // Sign-digit codes and the overflow marker digit
  localparam logic [7:0] SIGN_NEG   = 8'hBF;
  localparam logic [7:0] SIGN_BLANK = 8'hFF;
  localparam logic [7:0] SIGN_OVF   = 8'hC0;
  localparam logic [7:0] DIGIT_OVF  = 8'h8E;

  // Blank/blank pair, used as the reset sample and "already reported" value
  localparam logic [15:0] PAIR_BLANK = 16'hFFFF;

  typedef enum logic {
    SETTLE = 1'b0,
    REPORT = 1'b1
  } seg7_state_t;

  // Decoded report as presented on the output handshake
  typedef struct packed {
    logic [3:0] value;
    logic       ovf;
    logic       invalid;
  } seg7_report_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational lookup of one active-low digit pattern to its magnitude 0..8.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pattern,
  output logic       hit_c,
  output logic [3:0] mag_c
);

  // Exact-match table; anything else (including DP low) is a miss
  always_comb begin
    hit_c = 1'b1;
    mag_c = 4'd0;
    case (pattern)
      DIG_0:   mag_c = 4'd0;
      DIG_1:   mag_c = 4'd1;
      DIG_2:   mag_c = 4'd2;
      DIG_3:   mag_c = 4'd3;
      DIG_4:   mag_c = 4'd4;
      DIG_5:   mag_c = 4'd5;
      DIG_6:   mag_c = 4'd6;
      DIG_7:   mag_c = 4'd7;
      DIG_8:   mag_c = 4'd8;
      default: hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_signed_decoder.sv
// Recovers a signed 4-bit value / overflow flag from a sign+digit segment pair once the
// pattern has been stable long enough, and reports each new pattern once via valid/ready.
module seg7_signed_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       seg_sign,
  input  logic [7:0]       seg_digit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_value,
  output logic             out_ovf,
  output logic             out_invalid,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [15:0]      pair_c;
  logic [15:0]      sample_q;
  logic [CNT_W-1:0] cnt_q;

  logic             dig_hit_c;
  logic [3:0]       dig_mag_c;
  seg7_report_t     dec_c;

  seg7_state_t      state_q, state_d;
  seg7_report_t     rpt_q, rpt_d;
  logic             valid_q, valid_d;
  logic [15:0]      last_q, last_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign pair_c = {seg_sign, seg_digit};

  // Sample the segment pair every cycle and count how long it has been unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= PAIR_BLANK;
      cnt_q    <= '0;
    end else begin
      sample_q <= pair_c;
      if (pair_c == sample_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  seg7_digit_decode u_digit (
    .pattern (sample_q[7:0]),
    .hit_c   (dig_hit_c),
    .mag_c   (dig_mag_c)
  );

  // Map the sampled pair onto the legal encodings; -0 and +8 fall through to invalid
  always_comb begin
    dec_c         = '0;
    dec_c.invalid = 1'b0;
    if (sample_q[15:8] == SIGN_BLANK && dig_hit_c && dig_mag_c <= 4'd7) begin
      dec_c.value = dig_mag_c;
    end else if (sample_q[15:8] == SIGN_NEG && dig_hit_c && dig_mag_c != 4'd0) begin
      dec_c.value = 4'(4'd0 - dig_mag_c);
    end else if (sample_q[15:8] == SIGN_OVF && sample_q[7:0] == DIGIT_OVF) begin
      dec_c.ovf = 1'b1;
    end else begin
      dec_c.invalid = 1'b1;
    end
  end

  // Next-state: latch a new stable pattern in SETTLE, hold it in REPORT until accepted
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_MAX && sample_q != last_q) begin
          rpt_d   = dec_c;
          last_d  = sample_q;
          valid_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = SETTLE;
          if (rpt_q.invalid && err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // State, report and error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      rpt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= PAIR_BLANK;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_value   = rpt_q.value;
  assign out_ovf     = rpt_q.ovf;
  assign out_invalid = rpt_q.invalid;
  assign err_count   = err_q;

endmodule
